// File: rtl/dff_defs.sv
// dff_defs: shared edge-select encodings and default sizes for the register pipeline.
//   EDGE_NEG / EDGE_POS : values for the NEDGE parameter (1 = falling edge, 0 = rising edge)
//   DEF_WIDTH / DEF_DEPTH : default data width and stage count
package dff_defs;
    localparam bit EDGE_NEG  = 1'b1;
    localparam bit EDGE_POS  = 1'b0;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/dff_stage.sv
// dff_stage: one pipeline stage, a WIDTH-bit data register plus a valid flag on a selectable clock edge.
//   clock_i     : clock; NEDGE picks the active edge
//   reset_i     : synchronous active-low reset, loads RESET_VAL and clears valid
//   en_i        : capture d_i/d_valid_i when high, hold when low
//   flush_i     : clears valid only, data untouched, overrides en_i
//   d_i         : data in
//   d_valid_i   : valid flag in
//   q_o         : registered data
//   q_valid_o   : registered valid flag
module dff_stage
    import dff_defs::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter bit               NEDGE     = EDGE_NEG,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             d_valid_i,
    output logic [WIDTH-1:0] q_o,
    output logic             q_valid_o
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Priority: reset, then flush, then enable, then hold.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (!reset_i) begin
            data_d  = RESET_VAL;
            valid_d = 1'b0;
        end else if (flush_i) begin
            valid_d = 1'b0;
        end else if (en_i) begin
            data_d  = d_i;
            valid_d = d_valid_i;
        end
    end

    // Only one edge ever touches the state; the other edge is a no-op by construction.
    if (NEDGE == EDGE_POS) begin : g_pos
        always_ff @(posedge clock_i) begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end else begin : g_neg
        always_ff @(negedge clock_i) begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q_o       = data_q;
    assign q_valid_o = valid_q;
endmodule

// File: rtl/reg_pipe_nedge.sv
// reg_pipe_nedge: DEPTH-stage data/valid shift pipeline with selectable active clock edge and valid count.
//   clock_i     : clock; NEDGE=1 captures on falling edge, 0 on rising edge
//   reset_i     : synchronous active-low reset
//   d_i         : data into stage 0
//   d_valid_i   : valid flag travelling with d_i
//   en_i        : advance enable; low holds every stage
//   flush_i     : clears all valid flags, data kept
//   q_o         : data of the last stage
//   q_valid_o   : valid flag of the last stage
//   vld_cnt_o   : number of stages holding a valid word
module reg_pipe_nedge
    import dff_defs::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter bit               NEDGE     = EDGE_NEG,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic [WIDTH-1:0]           d_i,
    input  logic                       d_valid_i,
    input  logic                       en_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           q_o,
    output logic                       q_valid_o,
    output logic [$clog2(DEPTH+1)-1:0] vld_cnt_o
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [CW-1:0]    cnt;

    genvar i;
    for (i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] din;
        logic             vin;
        if (i == 0) begin : g_head
            assign din = d_i;
            assign vin = d_valid_i;
        end else begin : g_body
            assign din = data_q[i-1];
            assign vin = vld_q[i-1];
        end
        dff_stage #(
            .WIDTH    (WIDTH),
            .NEDGE    (NEDGE),
            .RESET_VAL(RESET_VAL)
        ) u_stage (
            .clock_i  (clock_i),
            .reset_i  (reset_i),
            .en_i     (en_i),
            .flush_i  (flush_i),
            .d_i      (din),
            .d_valid_i(vin),
            .q_o      (data_q[i]),
            .q_valid_o(vld_q[i])
        );
    end

    always_comb begin
        cnt = '0;
        for (int k = 0; k < DEPTH; k++) cnt = cnt + CW'(vld_q[k]);
    end

    assign q_o       = data_q[DEPTH-1];
    assign q_valid_o = vld_q[DEPTH-1];
    assign vld_cnt_o = cnt;
endmodule

// File: tb/tb_reg_pipe_nedge.sv
// tb_reg_pipe_nedge: directed scoreboard bench for a falling-edge 4-stage pipe and a rising-edge 1-stage pipe.
module tb_reg_pipe_nedge;
    logic       clk = 1'b0;
    logic       rst_n, en, flush, dv;
    logic [7:0] d, q;
    logic       qv;
    logic [2:0] cnt;
    logic       en2, flush2, dv2;
    logic [7:0] d2, q2;
    logic       qv2;
    logic       cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } ent_t;

    ent_t sb[$];

    always #5 clk = ~clk;

    reg_pipe_nedge #(.WIDTH(8), .DEPTH(4), .NEDGE(1'b1), .RESET_VAL(8'h00)) u_neg (
        .clock_i(clk), .reset_i(rst_n), .d_i(d), .d_valid_i(dv), .en_i(en), .flush_i(flush),
        .q_o(q), .q_valid_o(qv), .vld_cnt_o(cnt)
    );

    reg_pipe_nedge #(.WIDTH(8), .DEPTH(1), .NEDGE(1'b0), .RESET_VAL(8'h00)) u_pos (
        .clock_i(clk), .reset_i(rst_n), .d_i(d2), .d_valid_i(dv2), .en_i(en2), .flush_i(flush2),
        .q_o(q2), .q_valid_o(qv2), .vld_cnt_o(cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pc();
        int n = 0;
        foreach (sb[k]) n += int'(sb[k].v);
        return n;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic sb_reset();
        sb.delete();
        repeat (4) sb.push_back(ent_t'{d: 8'h00, v: 1'b0});
    endtask

    // sb[0] is the oldest in-flight word, i.e. the one sitting in the last stage.
    task automatic check_pipe(input string tag);
        chk({tag, ".q"}, q, sb[0].d);
        chk({tag, ".qv"}, qv, sb[0].v);
        chk({tag, ".cnt"}, cnt, pc());
    endtask

    task automatic adv(input logic [7:0] dd, input logic vv, input string tag);
        en = 1'b1;
        flush = 1'b0;
        d = dd;
        dv = vv;
        sb.push_back(ent_t'{d: dd, v: vv});
        tick();
        void'(sb.pop_front());
        check_pipe(tag);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; d = 8'hFF; dv = 1'b1; flush = 1'b0;
        en2 = 1'b1; d2 = 8'hFF; dv2 = 1'b1; flush2 = 1'b0;
        tick();
        tick();
        sb_reset();
        check_pipe("reset");
        chk("reset2.q", q2, 8'h00);
        chk("reset2.qv", qv2, 1'b0);
        chk("reset2.cnt", cnt2, 1'b0);
        en2 = 1'b0;
        rst_n = 1'b1;

        adv(8'hA1, 1'b1, "stream1");
        adv(8'hA2, 1'b1, "stream2");
        adv(8'hA3, 1'b1, "stream3");
        adv(8'hA4, 1'b1, "stream4");
        chk("stream.q_a1", q, 8'hA1);
        chk("stream.cnt4", cnt, 3'd4);

        d = 8'hEE; dv = 1'b0; en = 1'b1;
        @(posedge clk);
        #1;
        check_pipe("posedge");

        adv(8'hB1, 1'b1, "fill1");
        adv(8'hB2, 1'b1, "fill2");
        adv(8'hB3, 1'b1, "fill3");

        en = 1'b1; flush = 1'b1; d = 8'h55; dv = 1'b1;
        tick();
        foreach (sb[k]) sb[k].v = 1'b0;
        check_pipe("flush");
        chk("flush.q_kept", q, 8'hA4);

        adv(8'hC1, 1'b0, "drain1");
        adv(8'hC2, 1'b0, "drain2");
        adv(8'hC3, 1'b0, "drain3");

        adv(8'hD1, 1'b1, "stall_in");
        en = 1'b0; d = 8'hEE; dv = 1'b1;
        repeat (3) begin
            tick();
            check_pipe("stall");
        end
        adv(8'h00, 1'b0, "stall_out1");
        adv(8'h00, 1'b0, "stall_out2");
        adv(8'h00, 1'b0, "stall_out3");
        chk("stall.lat_q", q, 8'hD1);
        chk("stall.lat_qv", qv, 1'b1);

        adv(8'hF1, 1'b1, "mid1");
        adv(8'hF2, 1'b1, "mid2");
        rst_n = 1'b0; flush = 1'b1; en = 1'b1; d = 8'h99; dv = 1'b1;
        tick();
        sb_reset();
        check_pipe("midrst");
        rst_n = 1'b1;
        adv(8'h77, 1'b1, "post1");
        adv(8'h00, 1'b0, "post2");
        adv(8'h00, 1'b0, "post3");
        adv(8'h00, 1'b0, "post4");
        chk("post.q77", q, 8'h77);
        chk("post.qv", qv, 1'b1);

        d2 = 8'h3C; dv2 = 1'b1; en2 = 1'b1;
        @(posedge clk);
        #1;
        chk("pos.q", q2, 8'h3C);
        chk("pos.qv", qv2, 1'b1);
        chk("pos.cnt", cnt2, 1'b1);
        d2 = 8'hC3; dv2 = 1'b0;
        @(negedge clk);
        #1;
        chk("pos.neg_q", q2, 8'h3C);
        chk("pos.neg_qv", qv2, 1'b1);
        en2 = 1'b0;
        @(posedge clk);
        #1;
        chk("pos.hold_q", q2, 8'h3C);
        chk("pos.hold_qv", qv2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
